// File: rtl/ifu_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch_pkg : shared types and constants for the instruction fetch unit  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
package ifu_fetch_pkg;

    localparam int          c_stall_width = 2;
    localparam int          c_stall_pc    = 0;
    localparam int          c_stall_id    = 1;
    localparam logic [31:0] c_inst_nop    = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } ibuf_entry_t;

endpackage

`ifndef STALL_WIDTH
`define STALL_WIDTH ifu_fetch_pkg::c_stall_width
`endif
`ifndef STALL_PC
`define STALL_PC ifu_fetch_pkg::c_stall_pc
`endif
`ifndef STALL_ID
`define STALL_ID ifu_fetch_pkg::c_stall_id
`endif
`ifndef INST_NOP
`define INST_NOP ifu_fetch_pkg::c_inst_nop
`endif
`default_nettype wire

// File: rtl/ifu_ibuf.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_ibuf  : circular instruction buffer, push/pop/flush, full/empty/count   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module ifu_ibuf
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  ibuf_entry_t       push_data,
    input  logic              pop,
    input  logic              flush,
    output ibuf_entry_t       head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int               c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_full  = CNT_W'(DEPTH);

    ibuf_entry_t        r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;
    logic               w_do_push;

    // A full buffer still accepts a push when the head leaves in the same cycle
    assign w_do_pop  = pop & (r_count != '0);
    assign w_do_push = push & ((r_count != c_full) | w_do_pop);

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign head_data = r_mem[r_rd_ptr];
    assign full      = (r_count == c_full);
    assign empty     = (r_count == '0);
    assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ifu_fetch : instruction fetch unit, bus request FSM + instruction buffer   |
// |             IFU_PREFETCH_BUF_EN selects a two-entry prefetch buffer        |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [c_stall_width-1:0] stall_i,
    input  logic                     flush_i,
    input  logic [31:0]              jump_addr_i,
    output logic                     ibus_req_o,
    output logic [31:0]              ibus_addr_o,
    input  logic                     ibus_gnt_i,
    input  logic                     ibus_rvalid_i,
    input  logic [31:0]              ibus_rdata_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              inst_addr_o,
    output logic                     inst_valid_o
);

`ifdef IFU_PREFETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    fetch_state_e       r_state;
    logic               r_req;
    logic [31:0]        r_pc;
    logic [31:0]        r_ret_pc;
    logic [1:0]         r_outstanding;
    logic [1:0]         r_discard;

    ibuf_entry_t        w_head;
    ibuf_entry_t        w_push_data;
    logic               w_full;
    logic               w_empty;
    logic [c_cnt_w-1:0] w_count;
    logic               w_gnt_acc;
    logic               w_rv_disc;
    logic               w_rv_out;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_out_upd;
    logic [1:0]         w_disc_upd;
    logic [1:0]         w_out_next;
    logic [1:0]         w_disc_next;
    logic [1:0]         w_occ_next;
    logic [2:0]         w_total;
    logic               w_allow;

    // Responses retire discarded requests first; with nothing in flight they are ignored
    assign w_gnt_acc = r_req & ibus_gnt_i;
    assign w_rv_disc = ibus_rvalid_i & (r_discard != 2'd0);
    assign w_rv_out  = ibus_rvalid_i & (r_discard == 2'd0) & (r_outstanding != 2'd0);
    assign w_pop     = ~w_empty & ~stall_i[c_stall_id] & ~flush_i;
    assign w_push    = w_rv_out & ~flush_i & (~w_full | w_pop);

    assign w_out_upd   = r_outstanding + 2'(w_gnt_acc) - 2'(w_rv_out);
    assign w_disc_upd  = r_discard - 2'(w_rv_disc);
    assign w_out_next  = flush_i ? 2'd0 : w_out_upd;
    assign w_disc_next = flush_i ? (w_disc_upd + w_out_upd) : w_disc_upd;
    assign w_occ_next  = flush_i ? 2'd0 : (2'(w_count) + 2'(w_push) - 2'(w_pop));

    // Discarded requests still occupy the bus, so they count against the depth
    assign w_total = 3'(w_occ_next) + 3'(w_out_next) + 3'(w_disc_next);
    assign w_allow = ~stall_i[c_stall_pc] & (w_total < 3'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_req         <= 1'b0;
            r_pc          <= RESET_PC;
            r_ret_pc      <= RESET_PC;
            r_outstanding <= 2'd0;
            r_discard     <= 2'd0;
        end else begin
            r_outstanding <= w_out_next;
            r_discard     <= w_disc_next;
            if (flush_i) begin
                r_state  <= ST_FLUSH;
                r_req    <= 1'b0;
                r_pc     <= jump_addr_i;
                r_ret_pc <= jump_addr_i;
            end else begin
                if (w_push) r_ret_pc <= r_ret_pc + 32'd4;
                case (r_state)
                    ST_IDLE, ST_FLUSH: begin
                        r_state <= w_allow ? ST_REQ : ST_IDLE;
                        r_req   <= w_allow;
                    end
                    ST_REQ: begin
                        if (ibus_gnt_i) begin
                            r_pc    <= r_pc + 32'd4;
                            r_state <= w_allow ? ST_REQ : ST_IDLE;
                            r_req   <= w_allow;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_push_data = '{inst: ibus_rdata_i, addr: r_ret_pc};

    ifu_ibuf #(
        .DEPTH (DEPTH),
        .CNT_W (c_cnt_w)
    ) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .flush     (flush_i),
        .head_data (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    assign ibus_req_o   = r_req;
    assign ibus_addr_o  = r_pc;
    assign inst_valid_o = ~w_empty;
    assign inst_o       = w_empty ? c_inst_nop : w_head.inst;
    assign inst_addr_o  = w_empty ? 32'h0 : w_head.addr;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ifu_fetch : directed self-checking bench for ifu_fetch (default depth)  |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [c_stall_width-1:0] stall_i;
    logic                     flush_i;
    logic [31:0]              jump_addr_i;
    logic                     ibus_req_o;
    logic [31:0]              ibus_addr_o;
    logic                     ibus_gnt_i;
    logic                     ibus_rvalid_i;
    logic [31:0]              ibus_rdata_i;
    logic [31:0]              inst_o;
    logic [31:0]              inst_addr_o;
    logic                     inst_valid_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic auto_rsp;

    ifu_fetch #(.RESET_PC(32'h80)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkdata(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; with auto_rsp set, a grant is answered with rvalid in the next cycle
    task automatic tick();
        logic        granted;
        logic [31:0] gaddr;
        granted = ibus_req_o & ibus_gnt_i;
        gaddr   = ibus_addr_o;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            ibus_rvalid_i = granted;
            ibus_rdata_i  = granted ? mkdata(gaddr) : 32'h0;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"},       ibus_req_o,   1'b0);
        chk({tag, "_ivalid"},    inst_valid_o, 1'b0);
        chk({tag, "_inst_nop"},  inst_o,       c_inst_nop);
        chk({tag, "_inst_addr"}, inst_addr_o,  32'h0);
        chk({tag, "_pc"},        ibus_addr_o,  32'h80);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = '0; flush_i = 1'b0; jump_addr_i = 32'h0;
        ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0; auto_rsp = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");

        // Sequential fetch from RESET_PC with an always-granting bus
        rst_n = 1'b1; ibus_gnt_i = 1'b1; auto_rsp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("seq_req",       ibus_req_o,   1'b1);
            chk("seq_req_addr",  ibus_addr_o,  32'h80 + 32'(4 * k));
            chk("seq_ivalid_lo", inst_valid_o, 1'b0);
            tick();
            chk("seq_req_drop",  ibus_req_o,   1'b0);
            chk("seq_pc_adv",    ibus_addr_o,  32'h84 + 32'(4 * k));
            tick();
            chk("seq_ivalid",    inst_valid_o, 1'b1);
            chk("seq_inst_addr", inst_addr_o,  32'h80 + 32'(4 * k));
            chk("seq_inst",      inst_o,       mkdata(32'h80 + 32'(4 * k)));
        end

        // Grant withheld for three cycles: request and address held
        ibus_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("nognt_req",  ibus_req_o,  1'b1);
            chk("nognt_addr", ibus_addr_o, 32'h8C);
        end

        // Decode stall with the buffer full
        ibus_gnt_i = 1'b1; stall_i[c_stall_id] = 1'b1;
        tick();
        chk("stl_gnt_req", ibus_req_o, 1'b0);
        tick();
        chk("stl_ivalid", inst_valid_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("stl_no_req",    ibus_req_o,   1'b0);
            chk("stl_ivalid",    inst_valid_o, 1'b1);
            chk("stl_inst_addr", inst_addr_o,  32'h8C);
            chk("stl_inst",      inst_o,       mkdata(32'h8C));
        end
        stall_i[c_stall_id] = 1'b0;
        tick();
        chk("stl_rel_ivalid", inst_valid_o, 1'b0);
        chk("stl_rel_req",    ibus_req_o,   1'b1);
        chk("stl_rel_addr",   ibus_addr_o,  32'h90);

        // Flush with one request outstanding: its response must be dropped
        auto_rsp = 1'b0;
        tick();
        chk("fl_pre_req", ibus_req_o,  1'b0);
        chk("fl_pre_pc",  ibus_addr_o, 32'h94);
        flush_i = 1'b1; jump_addr_i = 32'h200;
        tick();
        chk("fl_req",    ibus_req_o,   1'b0);
        chk("fl_ivalid", inst_valid_o, 1'b0);
        chk("fl_pc",     ibus_addr_o,  32'h200);
        flush_i = 1'b0; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hDEAD_BEEF;
        tick();
        chk("fl_drop_ivalid", inst_valid_o, 1'b0);
        chk("fl_drop_inst",   inst_o,       c_inst_nop);
        chk("fl_new_req",     ibus_req_o,   1'b1);
        chk("fl_new_addr",    ibus_addr_o,  32'h200);
        ibus_rvalid_i = 1'b0; auto_rsp = 1'b1;
        tick();
        tick();
        chk("fl_tgt_ivalid", inst_valid_o, 1'b1);
        chk("fl_tgt_addr",   inst_addr_o,  32'h200);
        chk("fl_tgt_inst",   inst_o,       mkdata(32'h200));

        // PC wrap from the top of the address space
        flush_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC;
        tick();
        chk("wr_flush_ivalid", inst_valid_o, 1'b0);
        chk("wr_flush_pc",     ibus_addr_o,  32'hFFFF_FFFC);
        flush_i = 1'b0;
        tick();
        chk("wr_req",      ibus_req_o,  1'b1);
        chk("wr_req_addr", ibus_addr_o, 32'hFFFF_FFFC);
        tick();
        chk("wr_pc_zero", ibus_addr_o, 32'h0);
        tick();
        chk("wr_inst_addr", inst_addr_o, 32'hFFFF_FFFC);
        chk("wr_inst",      inst_o,      mkdata(32'hFFFF_FFFC));
        tick();
        chk("wr_next_req",  ibus_req_o,  1'b1);
        chk("wr_next_addr", ibus_addr_o, 32'h0);

        // Flush coinciding with rvalid, then reset while a request is in flight
        auto_rsp = 1'b0;
        tick();
        chk("fr_pre_pc", ibus_addr_o, 32'h4);
        ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_0001;
        flush_i = 1'b1; jump_addr_i = 32'h300;
        tick();
        chk("fr_ivalid", inst_valid_o, 1'b0);
        chk("fr_req",    ibus_req_o,   1'b0);
        chk("fr_pc",     ibus_addr_o,  32'h300);
        flush_i = 1'b0; ibus_rvalid_i = 1'b0;
        tick();
        chk("fr_ivalid2", inst_valid_o, 1'b0);
        chk("fr_req2",    ibus_req_o,   1'b1);
        chk("fr_addr2",   ibus_addr_o,  32'h300);
        tick();
        chk("fr_pc_adv", ibus_addr_o, 32'h304);
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        rst_n = 1'b1; ibus_rvalid_i = 1'b1; ibus_rdata_i = 32'hBAD0_0002;
        tick();
        chk("late_rv_ivalid", inst_valid_o, 1'b0);
        chk("late_rv_req",    ibus_req_o,   1'b1);
        chk("late_rv_addr",   ibus_addr_o,  32'h80);
        ibus_rvalid_i = 1'b0;
        tick();
        chk("late_rv_ivalid2", inst_valid_o, 1'b0);
        chk("late_rv_inst",    inst_o,       c_inst_nop);
        chk("late_rv_pc",      ibus_addr_o,  32'h84);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
